// File: rtl/gradient_stream_ctrl_if.sv
// Handshake and status bundle between the gradient stream controller and its neighbours.
// The slave modport is the controller's view; master is the upstream/consumer view.
interface gradient_stream_ctrl_if;
  logic       start;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_pixel;
  logic       s_ready;
  logic       dn_stall;
  logic       pix_en;
  logic [7:0] pix_out;
  logic       win_valid;
  logic [9:0] win_row;
  logic [9:0] win_col;
  logic       grad_valid;
  logic       busy;
  logic       frame_done;

  modport master (
    output start, abort, s_valid, s_pixel, dn_stall,
    input  s_ready, pix_en, pix_out, win_valid, win_row, win_col,
           grad_valid, busy, frame_done
  );

  modport slave (
    input  start, abort, s_valid, s_pixel, dn_stall,
    output s_ready, pix_en, pix_out, win_valid, win_row, win_col,
           grad_valid, busy, frame_done
  );
endinterface

// File: rtl/gradient_stream_ctrl.sv
// Frame sequencer for a WIN x WIN gradient window: accepts one frame of pixels, tracks
// row/col, flags interior window centres. Define GRAD_CTRL_STALL_CNT_EN for the stall_cnt port.
module gradient_stream_ctrl #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int WIN   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  gradient_stream_ctrl_if.slave  bus
`ifdef GRAD_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
  localparam logic [9:0] WIN_EDGE = 10'(WIN - 1);
  localparam logic [9:0] WIN_HALF = 10'(WIN / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       drain_cnt;
  logic [9:0] row;
  logic [9:0] col;
  logic       accept;
  logic       last_pix;
  logic       frame_start;
  logic       centre_hit;

  logic       pix_en_q;
  logic [7:0] pix_out_q;
  logic       win_valid_q;
  logic [9:0] win_row_q;
  logic [9:0] win_col_q;
  logic       grad_valid_q;

  // abort also closes the handshake so no pixel slips in during the cancel cycle
  assign bus.s_ready  = (state == S_RUN) && !bus.dn_stall && !bus.abort;
  assign accept       = bus.s_valid && bus.s_ready;
  assign last_pix     = (row == ROW_LAST) && (col == COL_LAST);
  assign frame_start  = (state == S_IDLE) && bus.start && !bus.abort;
  assign centre_hit   = accept && (row >= WIN_EDGE) && (col >= WIN_EDGE);

  assign bus.busy       = (state != S_IDLE);
  assign bus.frame_done = (state == S_DONE) && !bus.abort;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (accept && last_pix) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.abort) state_next = S_IDLE;
  end

  // Two DRAIN cycles flush the pix_en and grad_valid pipeline stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= 1'b0;
    end else if (state == S_DRAIN && !bus.abort) begin
      drain_cnt <= ~drain_cnt;
    end else begin
      drain_cnt <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (bus.abort || frame_start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // Pixel hand-off and window-centre flags, one cycle behind the accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en_q     <= 1'b0;
      pix_out_q    <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      grad_valid_q <= 1'b0;
    end else begin
      pix_en_q     <= accept;
      win_valid_q  <= centre_hit;
      grad_valid_q <= win_valid_q && !bus.abort;
      if (accept) begin
        pix_out_q <= bus.s_pixel;
      end
      if (centre_hit) begin
        win_row_q <= row - WIN_HALF;
        win_col_q <= col - WIN_HALF;
      end
    end
  end

  assign bus.pix_en     = pix_en_q;
  assign bus.pix_out    = pix_out_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.grad_valid = grad_valid_q;

`ifdef GRAD_CTRL_STALL_CNT_EN
  // Backpressure monitor: cycles where upstream had data but the consumer held off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (frame_start) begin
      stall_cnt <= '0;
    end else if (state == S_RUN && bus.s_valid && bus.dn_stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gradient_stream_ctrl.sv
// Directed bench for gradient_stream_ctrl at IMG_W=8, IMG_H=6, WIN=5; expected values hand-derived.
// Build with GRAD_CTRL_STALL_CNT_EN defined to also cover the stall counter.
module tb_gradient_stream_ctrl;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int WIN   = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  gradient_stream_ctrl_if bus ();

`ifdef GRAD_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  gradient_stream_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .WIN  (WIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef GRAD_CTRL_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard, sampled on the falling edge
  logic sb_clr = 1'b0;
  int acc_cnt, last_acc_cyc, pix_cnt, exp_pix, seq_err;
  int win_cnt, first_r, first_c, last_r, last_c, grad_cnt;
  int done_cnt, done_cyc, stall_rdy_err;

  always @(negedge clk) begin
    if (sb_clr) begin
      acc_cnt = 0; last_acc_cyc = 0; pix_cnt = 0; exp_pix = 0; seq_err = 0;
      win_cnt = 0; first_r = -1; first_c = -1; last_r = -1; last_c = -1;
      grad_cnt = 0; done_cnt = 0; done_cyc = 0; stall_rdy_err = 0;
    end else if (!rst) begin
      if (bus.s_valid && bus.s_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (bus.pix_en) begin
        if (int'(bus.pix_out) != (exp_pix % 256)) seq_err++;
        exp_pix++;
        pix_cnt++;
      end
      if (bus.win_valid) begin
        if (win_cnt == 0) begin
          first_r = int'(bus.win_row);
          first_c = int'(bus.win_col);
        end
        last_r = int'(bus.win_row);
        last_c = int'(bus.win_col);
        win_cnt++;
      end
      if (bus.grad_valid) grad_cnt++;
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.dn_stall && bus.s_ready) stall_rdy_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.s_pixel = acc_cnt[7:0];
  endtask

  task automatic clear_sb();
    sb_clr = 1'b1;
    @(negedge clk);
    #1;
    sb_clr = 1'b0;
  endtask

  task automatic begin_frame();
    clear_sb();
    step();
    bus.start   = 1'b1;
    bus.s_valid = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
    bus.s_valid  = 1'b0;
    bus.dn_stall = 1'b0;
    step();
    step();
    check({tag, "_frame_done_once"}, done_cnt, 1);
  endtask

  // 8x6 frame, WIN=5: centres (2..3, 2..5) -> 8 windows, first (2,2), last (3,5)
  task automatic check_frame(input string tag);
    check({tag, "_pix_en_cnt"}, pix_cnt, 48);
    check({tag, "_pix_seq_err"}, seq_err, 0);
    check({tag, "_win_cnt"}, win_cnt, 8);
    check({tag, "_first_row"}, first_r, 2);
    check({tag, "_first_col"}, first_c, 2);
    check({tag, "_last_row"}, last_r, 3);
    check({tag, "_last_col"}, last_c, 5);
    check({tag, "_grad_cnt"}, grad_cnt, 8);
    check({tag, "_busy_after"}, bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_pix_en"}, bus.pix_en, 0);
    check({tag, "_pix_out"}, bus.pix_out, 0);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_win_row"}, bus.win_row, 0);
    check({tag, "_win_col"}, bus.win_col, 0);
    check({tag, "_grad_valid"}, bus.grad_valid, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_left;
    bit stall_a, stall_b;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_pixel  = 8'd0;
    bus.dn_stall = 1'b0;
    clear_sb();

    #23;
    check_all_zero("reset");
    step();
    rst = 1'b0;
    step();

    // Plain frame: pixels 0..47 with s_valid held high
    begin_frame();
    wait_done("plain", 300);
    check_frame("plain");
    check("plain_done_latency", done_cyc - last_acc_cyc, 3);

    // Two stalls: 5 cycles after pixel 10, 2 cycles after pixel 30
    begin_frame();
    stall_left = 0;
    stall_a    = 1'b0;
    stall_b    = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      step();
      bus.dn_stall = 1'b0;
      if (stall_left > 0) begin
        bus.dn_stall = 1'b1;
        stall_left--;
      end else if (acc_cnt == 11 && !stall_a) begin
        stall_a      = 1'b1;
        bus.dn_stall = 1'b1;
        stall_left   = 4;
      end else if (acc_cnt == 31 && !stall_b) begin
        stall_b      = 1'b1;
        bus.dn_stall = 1'b1;
        stall_left   = 1;
      end
    end
    wait_done("stall", 50);
    check_frame("stall");
    check("stall_ready_during_stall", stall_rdy_err, 0);
`ifdef GRAD_CTRL_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 7);
`endif

    // Abort after 20 accepts, then a fresh frame
    begin_frame();
    for (int i = 0; i < 100 && acc_cnt < 20; i++) step();
    bus.abort = 1'b1;
    #1;
    check("abort_s_ready", bus.s_ready, 0);
    step();
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    repeat (6) step();
    check("abort_acc_cnt", acc_cnt, 20);
    check("abort_no_done", done_cnt, 0);
    begin_frame();
    wait_done("restart", 300);
    check_frame("restart");

    // start+abort together in IDLE, then start while running
    step();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    check("start_abort_busy", bus.busy, 0);
    begin_frame();
    for (int i = 0; i < 100 && acc_cnt < 13; i++) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("mid_start", 300);
    check_frame("mid_start");

    // Asynchronous reset in the middle of RUN
    begin_frame();
    for (int i = 0; i < 100 && acc_cnt < 38; i++) step();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    step();
    step();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    step();
    begin_frame();
    wait_done("post_rst", 300);
    check_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
